// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU opcode encoding used by alu_pipe and its users.
package cpu_types_pkg;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'h0,
    ALU_SRL  = 4'h1,
    ALU_ADD  = 4'h2,
    ALU_SUB  = 4'h3,
    ALU_AND  = 4'h4,
    ALU_OR   = 4'h5,
    ALU_XOR  = 4'h6,
    ALU_NOR  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9,
    ALU_MULU = 4'hA
  } aluop_t;

endpackage

// File: rtl/alu_mult.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// done is high during the final iteration; product then shows the finished result.
module alu_mult #(
  parameter int WIDTH = 32
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]      cnt;
  logic               busy;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     sum;

  // {hi, multiplier}: add multiplicand into hi when lsb set, then shift right
  assign sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
  assign product = {sum, acc[WIDTH-1:1]};
  assign done    = busy && (cnt == '0);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt   <= '0;
      busy  <= 1'b0;
      mcand <= '0;
      acc   <= '0;
    end else if (start) begin
      cnt   <= CW'(WIDTH - 1);
      busy  <= 1'b1;
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
    end else if (busy) begin
      acc <= product;
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake on both sides.
// ALU_PIPE_MULT_EN adds the iterative ALU_MULU multiply and the IDLE/MUL/HOLD FSM.
module alu_pipe
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  aluop_t           opcode,
  input  logic [WIDTH-1:0] portA,
  input  logic [WIDTH-1:0] portB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] outPort,
  output logic [WIDTH-1:0] outHi,
  output logic             negative,
  output logic             zero,
  output logic             overflow
);
  localparam int SW = $clog2(WIDTH);

  logic             accept;
  logic             ld;
  logic [WIDTH-1:0] res, sum, diff, nxt_lo, nxt_hi;
  logic             ovf, nxt_ovf;
  logic [SW-1:0]    sh;

  assign sum  = portA + portB;
  assign diff = portA - portB;
  assign sh   = portB[SW-1:0];

  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (opcode)
      ALU_SLL:  res = portA << sh;
      ALU_SRL:  res = portA >> sh;
      ALU_ADD: begin
        res = sum;
        ovf = (portA[WIDTH-1] == portB[WIDTH-1]) && (sum[WIDTH-1] != portA[WIDTH-1]);
      end
      ALU_SUB: begin
        res = diff;
        ovf = (portA[WIDTH-1] != portB[WIDTH-1]) && (diff[WIDTH-1] != portA[WIDTH-1]);
      end
      ALU_AND:  res = portA & portB;
      ALU_OR:   res = portA | portB;
      ALU_XOR:  res = portA ^ portB;
      ALU_NOR:  res = ~(portA | portB);
      ALU_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(portA) < $signed(portB)};
      ALU_SLTU: res = {{(WIDTH-1){1'b0}}, portA < portB};
      default: begin
        res = '0;
        ovf = 1'b0;
      end
    endcase
  end

`ifdef ALU_PIPE_MULT_EN
  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

  state_t             state, state_nxt;
  logic               mul_start, mul_done;
  logic [2*WIDTH-1:0] product;

  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (opcode == ALU_MULU);

  alu_mult #(.WIDTH(WIDTH)) u_mult (
    .CLK     (CLK),
    .nRST    (nRST),
    .start   (mul_start),
    .a       (portA),
    .b       (portB),
    .done    (mul_done),
    .product (product)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mul_start) state_nxt = MUL;
      MUL:     if (mul_done)  state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // multiply accept only pops; the product is loaded when the last iteration retires
  always_comb begin
    ld      = accept && !mul_start;
    nxt_lo  = res;
    nxt_hi  = '0;
    nxt_ovf = ovf;
    if (state == MUL && mul_done) begin
      ld      = 1'b1;
      nxt_lo  = product[WIDTH-1:0];
      nxt_hi  = product[2*WIDTH-1:WIDTH];
      nxt_ovf = 1'b0;
    end
  end
`else
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    ld      = accept;
    nxt_lo  = res;
    nxt_hi  = '0;
    nxt_ovf = ovf;
  end
`endif

  // a same-edge pop and push simply overwrites the result registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      out_valid <= 1'b0;
      outPort   <= '0;
      outHi     <= '0;
      negative  <= 1'b0;
      zero      <= 1'b1;
      overflow  <= 1'b0;
    end else if (ld) begin
      out_valid <= 1'b1;
      outPort   <= nxt_lo;
      outHi     <= nxt_hi;
      negative  <= nxt_lo[WIDTH-1];
      zero      <= (nxt_lo == '0);
      overflow  <= nxt_ovf;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=32): directed table, handshake/multiply/reset
// sequences, and randomized ops against an arithmetic reference model.
module tb_alu_pipe;
  import cpu_types_pkg::*;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic         CLK = 1'b0;
  logic         nRST = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  aluop_t       opcode = ALU_ADD;
  logic [W-1:0] portA = '0, portB = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] outPort, outHi;
  logic         negative, zero, overflow;

  int checks = 0;
  int errors = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .portA     (portA),
    .portB     (portB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .outPort   (outPort),
    .outHi     (outHi),
    .negative  (negative),
    .zero      (zero),
    .overflow  (overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    aluop_t       op;
    logic [W-1:0] a, b, lo;
    logic         n, z, v;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(aluop_t op, logic [W-1:0] a, b, lo, logic n, z, v);
    vec_t t;
    t.op = op; t.a = a; t.b = b; t.lo = lo; t.n = n; t.z = z; t.v = v;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference behaviour from the arithmetic definitions; lat = cycles from accept to out_valid.
  task automatic model(input aluop_t op, input logic [W-1:0] a, b,
                       output logic [W-1:0] lo, hi, output logic n, z, v, output int lat);
    longint      s;
    logic [63:0] p;
    int          amt;
    lo = '0; hi = '0; v = 1'b0; lat = 1;
    amt = int'(b % 32);
    case (op)
      ALU_SLL:  lo = a << amt;
      ALU_SRL:  lo = a >> amt;
      ALU_ADD: begin
        lo = a + b;
        s  = longint'($signed(a)) + longint'($signed(b));
        v  = (s > SMAX) || (s < SMIN);
      end
      ALU_SUB: begin
        lo = a - b;
        s  = longint'($signed(a)) - longint'($signed(b));
        v  = (s > SMAX) || (s < SMIN);
      end
      ALU_AND:  lo = a & b;
      ALU_OR:   lo = a | b;
      ALU_XOR:  lo = a ^ b;
      ALU_NOR:  lo = ~(a | b);
      ALU_SLT:  lo = ($signed(a) < $signed(b)) ? 1 : 0;
      ALU_SLTU: lo = (a < b) ? 1 : 0;
`ifdef ALU_PIPE_MULT_EN
      ALU_MULU: begin
        p   = 64'(a) * 64'(b);
        lo  = p[31:0];
        hi  = p[63:32];
        lat = W + 1;
      end
`endif
      default: lo = '0;
    endcase
    n = lo[W-1];
    z = (lo == 0);
  endtask

  // Drive one op, wait (bounded) for its result; out_ready is expected high.
  task automatic issue(input aluop_t op, input logic [W-1:0] a, b,
                       output logic [W-1:0] lo, hi, output logic n, z, v,
                       output int lat, output logic leak);
    @(negedge CLK);
    check("in_ready_before_issue", 64'(in_ready), 64'd1);
    in_valid = 1'b1; opcode = op; portA = a; portB = b;
    @(negedge CLK);
    in_valid = 1'b0;
    lat = 1; leak = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) leak = 1'b1;
      @(negedge CLK);
      lat++;
    end
    lo = outPort; hi = outHi; n = negative; z = zero; v = overflow;
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return W'($urandom_range(0, 40));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] lo, hi, elo, ehi;
    logic         n, z, v, en, ez, ev, leak;
    int           lat, elat, seen;
    aluop_t       op;
    logic [W-1:0] a, b;

    tbl[0]  = mk(ALU_ADD,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1, 0, 1);
    tbl[1]  = mk(ALU_SUB,  32'h5,         32'h5,         32'h0,         0, 1, 0);
    tbl[2]  = mk(ALU_SUB,  32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 0, 0, 1);
    tbl[3]  = mk(ALU_SLT,  32'hFFFF_FFFF, 32'h1,         32'h1,         0, 0, 0);
    tbl[4]  = mk(ALU_SLTU, 32'hFFFF_FFFF, 32'h1,         32'h0,         0, 1, 0);
    tbl[5]  = mk(ALU_SLL,  32'h1,         32'h1F,        32'h8000_0000, 1, 0, 0);
    tbl[6]  = mk(ALU_SRL,  32'h8000_0000, 32'h24,        32'h0800_0000, 0, 0, 0);
    tbl[7]  = mk(ALU_SRL,  32'h8000_0000, 32'h3F,        32'h1,         0, 0, 0);
    tbl[8]  = mk(ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1, 0, 0);
    tbl[9]  = mk(ALU_OR,   32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 0, 0, 0);
    tbl[10] = mk(ALU_XOR,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         0, 1, 0);
    tbl[11] = mk(ALU_NOR,  32'h0,         32'h0,         32'hFFFF_FFFF, 1, 0, 0);
    tbl[12] = mk(ALU_ADD,  32'hFFFF_FFFF, 32'h1,         32'h0,         0, 1, 0);
    tbl[13] = mk(aluop_t'(4'hF), 32'h5,   32'h6,         32'h0,         0, 1, 0);
    tbl[14] = mk(ALU_SUB,  32'h0,         32'h1,         32'hFFFF_FFFF, 1, 0, 0);

    // reset values while reset is held
    #2 nRST = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_outPort",   64'(outPort),   64'd0);
    check("rst_outHi",     64'(outHi),     64'd0);
    check("rst_negative",  64'(negative),  64'd0);
    check("rst_zero",      64'(zero),      64'd1);
    check("rst_overflow",  64'(overflow),  64'd0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    #1 check("rst_release_in_ready", 64'(in_ready), 64'd1);

    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, lo, hi, n, z, v, lat, leak);
      check($sformatf("vec%0d_outPort", i),  64'(lo),  64'(tbl[i].lo));
      check($sformatf("vec%0d_outHi", i),    64'(hi),  64'd0);
      check($sformatf("vec%0d_negative", i), 64'(n),   64'(tbl[i].n));
      check($sformatf("vec%0d_zero", i),     64'(z),   64'(tbl[i].z));
      check($sformatf("vec%0d_overflow", i), 64'(v),   64'(tbl[i].v));
      check($sformatf("vec%0d_latency", i),  64'(lat), 64'd1);
    end

    // multiply: 0xFFFF * 0xFFFF
    issue(ALU_MULU, 32'hFFFF, 32'hFFFF, lo, hi, n, z, v, lat, leak);
`ifdef ALU_PIPE_MULT_EN
    check("mulu_latency", 64'(lat), 64'd33);
    check("mulu_outPort", 64'(lo),  64'hFFFE_0001);
    check("mulu_outHi",   64'(hi),  64'd0);
    check("mulu_negative", 64'(n),  64'd1);
    check("mulu_ready_low_while_busy", 64'(leak), 64'd0);
    check("mulu_ready_low_in_hold", 64'(in_ready), 64'd0);
    @(negedge CLK);
    check("mulu_ready_after_pop", 64'(in_ready), 64'd1);
    check("mulu_valid_after_pop", 64'(out_valid), 64'd0);
    issue(ALU_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lo, hi, n, z, v, lat, leak);
    check("mulu_max_outPort", 64'(lo), 64'h1);
    check("mulu_max_outHi",   64'(hi), 64'hFFFF_FFFE);
`else
    check("mulu_off_latency", 64'(lat), 64'd1);
    check("mulu_off_outPort", 64'(lo),  64'd0);
    check("mulu_off_zero",    64'(z),   64'd1);
    check("mulu_off_outHi",   64'(hi),  64'd0);
`endif

    // backpressure: result held while consumer stalls, then pop+push on one edge
    @(negedge CLK);
    out_ready = 1'b0;
    in_valid = 1'b1; opcode = ALU_ADD; portA = 32'd1; portB = 32'd2;
    @(negedge CLK);
    check("bp_first_valid", 64'(out_valid), 64'd1);
    check("bp_first_outPort", 64'(outPort), 64'd3);
    opcode = ALU_SUB; portA = 32'd10; portB = 32'd4;
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check($sformatf("bp_hold%0d_outPort", k), 64'(outPort), 64'd3);
      check($sformatf("bp_hold%0d_valid", k),   64'(out_valid), 64'd1);
      check($sformatf("bp_hold%0d_in_ready", k), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1 check("bp_in_ready_on_pop", 64'(in_ready), 64'd1);
    @(negedge CLK);
    in_valid = 1'b0;
    check("bp_second_valid",   64'(out_valid), 64'd1);
    check("bp_second_outPort", 64'(outPort),   64'd6);
    @(negedge CLK);
    check("bp_drained", 64'(out_valid), 64'd0);

    // reset ten cycles into a multiply: nothing may be presented afterwards
    @(negedge CLK);
    in_valid = 1'b1; opcode = ALU_MULU; portA = 32'hFFFF; portB = 32'hFFFF;
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (9) @(negedge CLK);
    nRST = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_outPort",   64'(outPort),   64'd0);
    check("midrst_zero",      64'(zero),      64'd1);
    @(negedge CLK);
    nRST = 1'b1;
    #1 check("midrst_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (40) begin
      @(negedge CLK);
      if (out_valid) seen++;
    end
    check("midrst_no_stale_result", 64'(seen), 64'd0);

    // randomized ops against the reference model
    for (int r = 0; r < 250; r++) begin
      op = aluop_t'($urandom_range(0, 15));
      a  = rnd_operand();
      b  = rnd_operand();
      if (op == ALU_MULU && $urandom_range(0, 1) == 0) begin
        a = a & 32'hFFFF;
        b = b & 32'h1FFFF;
      end
      model(op, a, b, elo, ehi, en, ez, ev, elat);
      issue(op, a, b, lo, hi, n, z, v, lat, leak);
      check($sformatf("rnd%0d_op%0h_outPort", r, op), 64'(lo), 64'(elo));
      check($sformatf("rnd%0d_op%0h_outHi", r, op),   64'(hi), 64'(ehi));
      check($sformatf("rnd%0d_op%0h_flags", r, op),   64'({n, z, v}), 64'({en, ez, ev}));
      check($sformatf("rnd%0d_op%0h_latency", r, op), 64'(lat), 64'(elat));
      check($sformatf("rnd%0d_op%0h_ready_leak", r, op), 64'(leak), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
